// File: rtl/anden_pkg.sv
// Shared types and constants for the anden instruction-fetch slice.
package anden_pkg;

  localparam int ANDEN_XLEN = 32;
  localparam logic [ANDEN_XLEN-1:0] ANDEN_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ANDEN_XLEN-1:0] pc;
    logic [ANDEN_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/anden_fifo.sv
// Power-of-two circular FIFO with a combinational head, flush and an occupancy count.
module anden_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;

  assign head = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // When full, a same-cycle pop frees the slot being overwritten.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/anden_fetch_unit.sv
// Instruction fetch: issues word fetches, queues in-order responses for decode, handles redirects.
module anden_fetch_unit
  import anden_pkg::*;
#(
  parameter int              XLEN     = ANDEN_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ANDEN_RESET_PC),
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  input  logic            id_ready
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0]   fpc, rpc, tgt;
  logic [CW-1:0]     out_cnt, drop_cnt, q_cnt;
  logic [SW-1:0]     inflight;
  logic [2*XLEN-1:0] head;
  logic              fire, push, pop, resp_drop;

  assign tgt = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  // Old-path responses still in flight also hold a slot, so drop_cnt + outstanding never exceeds QDEPTH.
  assign inflight       = SW'(q_cnt) + SW'(out_cnt) + SW'(drop_cnt);
  assign imem_req_valid = rst_n && !redirect_valid && (inflight < SW'(QDEPTH));
  assign imem_req_addr  = fpc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign push      = rst_n && imem_resp_valid && (drop_cnt == '0) && !redirect_valid;

  assign if_valid = rst_n && (q_cnt != '0);
  assign pop      = if_valid && id_ready && !redirect_valid;
  assign if_pc    = head[2*XLEN-1:XLEN];
  assign if_inst  = head[XLEN-1:0];

  anden_fifo #(.WIDTH(2*XLEN), .DEPTH(QDEPTH)) u_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rpc, imem_resp_data}),
    .pop       (pop),
    .head      (head),
    .count     (q_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fpc      <= tgt;
      rpc      <= tgt;
      out_cnt  <= '0;
      // Everything still in flight becomes stale; a response arriving now is the oldest of them.
      drop_cnt <= drop_cnt + out_cnt - CW'(imem_resp_valid);
    end else begin
      if (fire)      fpc      <= fpc + XLEN'(4);
      if (push)      rpc      <= rpc + XLEN'(4);
      if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
      out_cnt <= out_cnt + CW'(fire) - CW'(push);
    end
  end

endmodule

// File: tb/tb_anden_fetch_unit.sv
// Bench for anden_fetch_unit: vector table, directed corner sequences, randomized run vs. a PC-stream model.
module tb_anden_fetch_unit;
  import anden_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic        id_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  anden_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [31:0] exp_pc);
    fetch_entry_t got, want;
    got  = '{pc: if_pc, inst: if_inst};
    want = '{pc: exp_pc, inst: inst_of(exp_pc)};
    chk(nm, got, want);
  endtask

  // One clock cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic step(input logic rd, input logic [31:0] tgt, input logic rdy, input logic rv,
                      input logic [31:0] rdata, input logic idr);
    @(posedge clk); #1;
    rst_n = 1'b1; redirect_valid = rd; redirect_pc = tgt; imem_req_ready = rdy;
    imem_resp_valid = rv; imem_resp_data = rdata; id_ready = idr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = $urandom; id_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst req_valid", imem_req_valid, 0);
      chk("rst if_valid", if_valid, 0);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy, rv;
    logic [31:0] rpc;
    logic        idr;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_pc;
    string       nm;
  } vec_t;

  function automatic vec_t mk(input logic rst, rdy, rv, input logic [31:0] rpc, input logic idr,
                              input logic e_rv, input logic [31:0] e_ra,
                              input logic e_iv, input logic [31:0] e_pc, input string nm);
    vec_t v;
    v = '{rst: rst, rdy: rdy, rv: rv, rpc: rpc, idr: idr, e_rv: e_rv, e_ra: e_ra,
          e_iv: e_iv, e_pc: e_pc, nm: nm};
    return v;
  endfunction

  vec_t        tv[$];
  logic [31:0] maddr[$];
  int          mtime[$];

  initial begin
    // Latency-1 memory, everything ready: one request per cycle, head two cycles behind.
    for (int c = 0; c < 6; c++)
      tv.push_back(mk(c == 0, 1, c >= 1, 32'(4*(c-1)), 1, 1, 32'(4*c), c >= 2, 32'(4*(c-2)), "steady"));
    // Decode stalled: four requests fill the queue, then drain 0x0..0xC with memory not ready.
    tv.push_back(mk(1, 1, 0, 32'h0, 0, 1, 32'h00, 0, 32'h0, "stall"));
    tv.push_back(mk(0, 1, 1, 32'h0, 0, 1, 32'h04, 0, 32'h0, "stall"));
    tv.push_back(mk(0, 1, 1, 32'h4, 0, 1, 32'h08, 1, 32'h0, "stall"));
    tv.push_back(mk(0, 1, 1, 32'h8, 0, 1, 32'h0C, 1, 32'h0, "stall"));
    tv.push_back(mk(0, 1, 1, 32'hC, 0, 0, 32'h00, 1, 32'h0, "stall"));
    tv.push_back(mk(0, 1, 0, 32'h0, 0, 0, 32'h00, 1, 32'h0, "stall"));
    tv.push_back(mk(0, 0, 0, 32'h0, 1, 0, 32'h00, 1, 32'h0, "stall"));
    tv.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'h10, 1, 32'h4, "stall"));
    tv.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'h10, 1, 32'h8, "stall"));
    tv.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'h10, 1, 32'hC, "stall"));
    tv.push_back(mk(0, 0, 0, 32'h0, 0, 1, 32'h10, 0, 32'h0, "stall"));

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      step(0, 0, tv[i].rdy, tv[i].rv, inst_of(tv[i].rpc), tv[i].idr);
      chk($sformatf("%s[%0d] req_valid", tv[i].nm, i), imem_req_valid, tv[i].e_rv);
      if (tv[i].e_rv) chk($sformatf("%s[%0d] req_addr", tv[i].nm, i), imem_req_addr, tv[i].e_ra);
      chk($sformatf("%s[%0d] if_valid", tv[i].nm, i), if_valid, tv[i].e_iv);
      if (tv[i].e_iv) chk_head($sformatf("%s[%0d] head", tv[i].nm, i), tv[i].e_pc);
    end

    // Redirect with two requests outstanding: both responses dropped.
    do_reset();
    step(0, 0, 1, 0, 0, 0);               chk("rd2 addr0", imem_req_addr, 32'h0);
    step(0, 0, 1, 0, 0, 0);               chk("rd2 addr4", imem_req_addr, 32'h4);
    step(1, 32'h100, 0, 0, 0, 0);         chk("rd2 no req in redirect", imem_req_valid, 0);
    step(0, 0, 1, 1, inst_of(32'h0), 0);
    chk("rd2 req valid", imem_req_valid, 1);
    chk("rd2 req 0x100", imem_req_addr, 32'h100);
    chk("rd2 if_valid after redirect", if_valid, 0);
    step(0, 0, 0, 1, inst_of(32'h4), 0);  chk("rd2 drop0", if_valid, 0);
    step(0, 0, 0, 1, inst_of(32'h100), 0); chk("rd2 drop1", if_valid, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rd2 if_valid", if_valid, 1);
    chk_head("rd2 head 0x100", 32'h100);
    step(0, 0, 0, 0, 0, 0);               chk("rd2 drained", if_valid, 0);

    // Memory not ready for three cycles: address held, no skip, no duplicate.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("hold valid", imem_req_valid, 1);
      chk("hold addr", imem_req_addr, 32'h0);
    end
    step(0, 0, 1, 0, 0, 0);               chk("hold accept addr", imem_req_addr, 32'h0);
    step(0, 0, 1, 1, inst_of(32'h0), 0);  chk("hold next addr", imem_req_addr, 32'h4);
    step(0, 0, 0, 1, inst_of(32'h4), 1);  chk_head("hold head0", 32'h0);
    step(0, 0, 0, 0, 0, 1);               chk_head("hold head4", 32'h4);
    step(0, 0, 0, 0, 0, 1);               chk("hold no dup", if_valid, 0);

    // Redirect coinciding with a response and a pop.
    do_reset();
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, inst_of(32'h0), 0);
    step(0, 0, 0, 0, 0, 0);               chk_head("coll head0", 32'h0);
    step(1, 32'h200, 1, 1, inst_of(32'h4), 1); chk("coll no req", imem_req_valid, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("coll if_valid low", if_valid, 0);
    chk("coll req 0x200", imem_req_addr, 32'h200);
    step(0, 0, 0, 1, inst_of(32'h200), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("coll new entry kept", if_valid, 1);
    chk_head("coll head 0x200", 32'h200);

    // Address wrap at the top of the address space; low target bits ignored.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);               chk("wrap top addr", imem_req_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 1, inst_of(32'hFFFF_FFFC), 0); chk("wrap next addr", imem_req_addr, 32'h0);
    step(0, 0, 0, 1, inst_of(32'h0), 1); chk_head("wrap head top", 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 1);              chk_head("wrap head 0", 32'h0);

    // Randomized run: fetch and decode streams must follow pc, pc+4, ... from the last redirect.
    begin
      logic [31:0] exp_f, exp_d, prev_addr, tgt, rdata;
      logic        prev_hold, prev_rd, rd, rdy, rv, idr;
      int          pops, cyc;
      do_reset();
      exp_f = 0; exp_d = 0; prev_hold = 0; prev_rd = 0; prev_addr = 0; pops = 0; cyc = 0;
      maddr.delete(); mtime.delete();
      for (int n = 0; n < 3000; n++) begin
        rd  = ($urandom_range(24) == 0);
        tgt = $urandom;
        rdy = ($urandom_range(3) != 0);
        idr = ($urandom_range(2) != 0);
        rv = 0; rdata = $urandom;
        if (maddr.size() > 0 && mtime[0] <= cyc && $urandom_range(3) != 0) begin
          rv = 1; rdata = inst_of(maddr.pop_front()); void'(mtime.pop_front());
        end
        step(rd, tgt, rdy, rv, rdata, idr);
        if (rd) chk("rnd redirect no req", imem_req_valid, 0);
        if (prev_rd) chk("rnd if_valid after redirect", if_valid, 0);
        if (prev_hold && !rd) begin
          chk("rnd hold valid", imem_req_valid, 1);
          chk("rnd hold addr", imem_req_addr, prev_addr);
        end
        if (imem_req_valid && rdy && !rd) begin
          chk("rnd req addr", imem_req_addr, exp_f);
          maddr.push_back(imem_req_addr);
          mtime.push_back(cyc + 1 + int'($urandom_range(3)));
          exp_f += 4;
        end
        if (if_valid && idr && !rd) begin
          chk_head("rnd head", exp_d);
          exp_d += 4;
          pops++;
        end
        if (rd) begin
          exp_f = tgt & 32'hFFFF_FFFC;
          exp_d = exp_f;
        end
        prev_hold = imem_req_valid && !rdy && !rd;
        prev_addr = imem_req_addr;
        prev_rd   = rd;
        cyc++;
      end
      chk("rnd throughput", 64'(pops > 300), 1);
    end

    // Reset in the middle of traffic behaves like power-up.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("post-reset req_valid", imem_req_valid, 1);
    chk("post-reset req_addr", imem_req_addr, 32'h0);
    chk("post-reset if_valid", if_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anden_fetch_unit.md
ANDEN_FETCH_UNIT -- requirements
Module: anden_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have parameter QDEPTH, default 4, power of two >= 2: prefetch queue entries.
REQ-004 SHALL have clk, input, 1: clock, all state updates on its rising edge.
REQ-005 SHALL have rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have redirect_valid, input, 1: redirect request from the branch/exception unit.
REQ-007 SHALL have redirect_pc, input, XLEN: redirect target; bits [1:0] ignored and treated as zero.
REQ-008 SHALL have imem_req_valid, output, 1: fetch request valid.
REQ-009 SHALL have imem_req_addr, output, XLEN: fetch address, word aligned.
REQ-010 SHALL have imem_req_ready, input, 1: memory accepts the request.
REQ-011 SHALL have imem_resp_valid, input, 1: in-order response valid, latency >= 1 cycle.
REQ-012 SHALL have imem_resp_data, input, XLEN: fetched instruction word.
REQ-013 SHALL have if_valid, output, 1: decode-side entry valid.
REQ-014 SHALL have if_pc, output, XLEN: PC of the head entry.
REQ-015 SHALL have if_inst, output, XLEN: instruction of the head entry.
REQ-016 SHALL have id_ready, input, 1: decode consumes the head entry when if_valid && id_ready.

Function
REQ-017 SHALL hold fetch PC register fpc; imem_req_addr = fpc.
REQ-018 SHALL assert imem_req_valid only if (queue count + outstanding) < QDEPTH and redirect_valid is low.
REQ-019 SHALL, on an accepted request (valid && ready), set fpc = fpc + 4 (mod 2^XLEN, wrap silent) and increment outstanding.
REQ-020 SHALL hold imem_req_valid and imem_req_addr stable while valid && !ready, unless redirect_valid.
REQ-021 SHALL push {pc, data} into the queue on each non-dropped response, with pc tracked by a response-PC register advancing by 4 per push.
REQ-022 SHALL present the queue head combinationally on if_valid/if_pc/if_inst; no bypass: a response shows on if_valid no earlier than the next cycle.
REQ-023 SHALL never overflow the queue; REQ-018 guarantees space for every outstanding response.
REQ-024 SHALL support simultaneous push and pop in one cycle, including when full or when 1 entry.
REQ-025 SHALL, on redirect_valid: flush the queue, set fpc and response-PC to redirect_pc, set drop_cnt = outstanding minus 1 if imem_resp_valid that cycle else outstanding, and set outstanding = 0.
REQ-026 SHALL discard responses while drop_cnt > 0, decrementing drop_cnt per discarded response.
REQ-027 SHALL issue no request in the redirect cycle; the first request to redirect_pc is issued the following cycle.
REQ-028 SHALL give redirect priority over a same-cycle pop, push, or request acceptance; the popped entry is considered consumed by decode.
REQ-029 SHALL keep if_valid low in the cycle after a redirect.
REQ-030 SHALL count outstanding and drop_cnt in clog2(QDEPTH)+1 bits.

Reset
REQ-031 SHALL, while rst_n is low, set fpc = RESET_PC, response-PC = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0.
REQ-032 SHALL drive imem_req_valid = 0 and if_valid = 0 during reset.
REQ-033 SHALL issue the first request (addr RESET_PC) in the first cycle rst_n is high.
REQ-034 SHALL ignore responses arriving during reset; reset mid-operation SHALL behave identically to reset from power-up.

Structure
REQ-035 SHALL place the fetch-entry struct {pc, inst} and the default RESET_PC constant in shared package anden_pkg.
REQ-036 SHALL implement the queue as sub-module anden_fifo (parameters WIDTH, DEPTH; push/pop/flush/count; synchronous rst_n).
REQ-037 SHALL register all state in always_ff and use no latches.

Verification
REQ-038 Reset release, memory latency 1, ready=1, id_ready=1 -> requests 0x0,0x4,0x8 on consecutive cycles; if_pc 0x0 two cycles after first request.
REQ-039 id_ready=0 with QDEPTH=4 -> exactly 4 requests issued, then imem_req_valid low; queue holds pc 0x0..0xC in order.
REQ-040 Redirect to 0x100 with 2 requests outstanding -> next 2 responses dropped, first if_pc after redirect is 0x100, no request in the redirect cycle.
REQ-041 imem_req_ready low for 3 cycles -> imem_req_addr held constant, no duplicate request, no skipped PC.
REQ-042 Redirect in the same cycle as a response and a pop -> response dropped, drop_cnt = outstanding-1, if_valid low the next cycle.
REQ-043 fpc = 0xFFFF_FFFC accepted -> next request address 0x0000_0000.
